// File: rtl/uart_pkg.sv
// Shared types and helpers for the parameterised UART transmitter.
// Holds the FSM state enum, parity_mode encodings and baud divider math.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  function automatic int unsigned calc_bps_cnt(
    input int unsigned clk_freq,
    input int unsigned bps
  );
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit buffer with registered full/empty flags.
// Ports: clk_i, rst_i (async high), push_i/wdata_i, pop_i/rdata_o,
//        full_o, empty_o, level_o (occupancy).
module uart_tx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
    full_d  = (lvl_d == LW'(DEPTH));
    empty_d = (lvl_d == '0);
  end

  // full_q resets high so nothing is accepted until the first
  // edge after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      full_q  <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO, frame FSM, shifter, registered line.
// Ports: CLK_SYS, CLK_RST (async high), tx_valid/tx_ready/tx_data,
//        parity_mode, tx_busy, fifo_level, uart_txd (idle high).
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_SYS,
  input  logic                          CLK_RST,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic [1:0]                    parity_mode,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          uart_txd
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int BIT_W   = $clog2(DATA_BITS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stp_q, stp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;

  logic                 f_full;
  logic                 f_empty;
  logic [DATA_BITS-1:0] f_rdata;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 data_last;
  logic                 stop_last;
  logic                 frame_end;
  logic                 par_on;
  logic                 par_bit;

  assign tx_ready = ~f_full;
  assign push     = tx_valid & tx_ready;

  uart_tx_fifo #(
    .DW    (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK_SYS),
    .rst_i   (CLK_RST),
    .push_i  (push),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (fifo_level)
  );

  assign bit_end   = (baud_q == CNT_W'(BPS_CNT - 1));
  assign data_last = (bit_q == BIT_W'(DATA_BITS - 1));
  assign stop_last = (stp_q == 1'(STOP_BITS - 1));
  assign frame_end = (state_q == STOP) & bit_end & stop_last;

  // Pop from IDLE or straight out of the last stop bit so that
  // queued frames follow each other with no idle gap.
  assign pop = ~f_empty & ((state_q == IDLE) | frame_end);

`ifdef UART_TX_PARITY_EN
  logic pen_q;
  logic par_q;

  // Mode and parity value are latched with the word, so a change
  // of parity_mode mid-frame has no effect on the current frame.
  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      pen_q <= 1'b0;
      par_q <= 1'b0;
    end else if (pop) begin
      pen_q <= (parity_mode == PAR_EVEN) |
               (parity_mode == PAR_ODD);
      par_q <= (^f_rdata) ^ (parity_mode == PAR_ODD);
    end
  end

  assign par_on  = pen_q;
  assign par_bit = par_q;
`else
  logic unused_par;
  assign unused_par = ^parity_mode;
  assign par_on     = 1'b0;
  assign par_bit    = 1'b1;
`endif

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!f_empty) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && data_last)
                 state_d = par_on ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (frame_end)
                 state_d = f_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      PARITY:  txd_d = par_bit;
      default: txd_d = 1'b1;
    endcase
  end

  // Bit timer and indices restart on every state entry.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    stp_d   = stp_q;
    shift_d = shift_q;
    if (state_d != state_q) begin
      baud_d = '0;
      bit_d  = '0;
      stp_d  = 1'b0;
    end else if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if (bit_end && state_q == DATA) bit_d = bit_q + 1'b1;
      if (bit_end && state_q == STOP) stp_d = stp_q + 1'b1;
    end
    if (pop)
      shift_d = f_rdata;
    else if (bit_end && state_q == DATA)
      shift_d = shift_q >> 1;
  end

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      baud_q  <= '0;
      bit_q   <= '0;
      stp_q   <= 1'b0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stp_q   <= stp_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != IDLE) | (fifo_level != '0);

endmodule
